// File: rtl/screen_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : screen_fill_ctrl_if
//  Description : CPU port, fill-command handshake and RAM port-A signals
//                shared by the rectangle-fill controller and its neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
interface screen_fill_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [11:0] cpu_din;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0;
    logic [7:0]  cmd_x1;
    logic [7:0]  cmd_y0;
    logic [7:0]  cmd_y1;
    logic [11:0] cmd_color;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_din;
    logic        busy;
    logic        done;
    logic        cmd_err;

    // Requester side: CPU path and command source
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        input  cmd_ready, mem_we, mem_addr, mem_din, busy, done, cmd_err
    );

    // Controller side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        output cmd_ready, mem_we, mem_addr, mem_din, busy, done, cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/screen_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : screen_fill_ctrl
//  Description : Shares screen RAM port A between CPU traffic (always wins)
//                and a rectangle-fill engine that writes in free cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_fill_ctrl #(
    parameter int SCR_W = 200,
    parameter int SCR_H = 150
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    screen_fill_ctrl_if.slave  bus
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_FILL  = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;
    localparam logic [14:0] c_SCR_W = 15'(SCR_W);
    localparam logic [14:0] c_SCR_H = 15'(SCR_H);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_x0;
    logic [7:0]  r_x1;
    logic [7:0]  r_y1;
    logic [11:0] r_color;
    logic [14:0] r_row_base;
    logic        r_err;

    logic        w_cmd_ready;
    logic        w_accept;
    logic        w_cmd_bad;
    logic        w_eng_wr;
    logic        w_last_col;
    logic        w_last_row;
    logic [14:0] w_y0_ext;
    logic [14:0] w_row_base_init;
    logic        w_mem_we;
    logic [14:0] w_mem_addr;
    logic [11:0] w_mem_din;

    assign w_cmd_ready     = (r_state == S_IDLE) && rstn;
    assign w_accept        = bus.cmd_valid && w_cmd_ready;
    assign w_cmd_bad       = (bus.cmd_x0 > bus.cmd_x1) || (bus.cmd_y0 > bus.cmd_y1) ||
                             ({7'd0, bus.cmd_x1} >= c_SCR_W) ||
                             ({7'd0, bus.cmd_y1} >= c_SCR_H);
    // Engine writes are also gated by reset so an abort takes effect in the same cycle
    assign w_eng_wr        = (r_state == S_FILL) && !bus.cpu_req && rstn;
    assign w_last_col      = (r_x == r_x1);
    assign w_last_row      = (r_y == r_y1);
    assign w_y0_ext        = {7'd0, bus.cmd_y0};
    assign w_row_base_init = w_y0_ext * c_SCR_W;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_cmd_bad) w_state_nxt = S_FILL;
            S_FILL:  if (w_eng_wr && w_last_col && w_last_row) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = bus.cpu_addr;
        w_mem_din  = bus.cpu_din;
        if (bus.cpu_req) begin
            w_mem_we = bus.cpu_we;
        end else if (w_eng_wr) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_row_base + {7'd0, r_x};
            w_mem_din  = r_color;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.busy      = (r_state == S_FILL);
    assign bus.done      = (r_state == S_DONE);
    assign bus.cmd_err   = r_err;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_din   = w_mem_din;

    // Raster-order pixel walk; counters hold on CPU stall cycles
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_x        <= 8'd0;
            r_y        <= 8'd0;
            r_x0       <= 8'd0;
            r_x1       <= 8'd0;
            r_y1       <= 8'd0;
            r_color    <= 12'd0;
            r_row_base <= 15'd0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_accept && w_cmd_bad;
            if (w_accept && !w_cmd_bad) begin
                r_x        <= bus.cmd_x0;
                r_y        <= bus.cmd_y0;
                r_x0       <= bus.cmd_x0;
                r_x1       <= bus.cmd_x1;
                r_y1       <= bus.cmd_y1;
                r_color    <= bus.cmd_color;
                r_row_base <= w_row_base_init;
            end else if (w_eng_wr) begin
                if (!w_last_col) begin
                    r_x <= r_x + 8'd1;
                end else if (!w_last_row) begin
                    r_x        <= r_x0;
                    r_y        <= r_y + 8'd1;
                    r_row_base <= r_row_base + c_SCR_W;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_screen_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_screen_fill_ctrl
//  Description : Directed command table plus reset-abort sequence for the
//                screen fill controller, with a raster-order address model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_fill_ctrl;

    localparam int SCR_W = 200;
    localparam int SCR_H = 150;

    typedef struct {
        logic [7:0]  x0;
        logic [7:0]  x1;
        logic [7:0]  y0;
        logic [7:0]  y1;
        logic [11:0] color;
        int          stall_lo;
        int          stall_hi;
        bit          exp_err;
        int          exp_n;
        int          exp_first;
        int          exp_last;
        int          exp_end_cyc;
    } vec_t;

    logic clk;
    logic rstn;
    int   n_vec  = 0;
    int   n_miss = 0;

    screen_fill_ctrl_if bus ();

    screen_fill_ctrl #(.SCR_W(SCR_W), .SCR_H(SCR_H)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cpu_idle();
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 15'd0;
        bus.cpu_din  = 12'd0;
    endtask

    // Issue one command and follow it to its done or cmd_err pulse
    task automatic run_vec(input vec_t v, input string tag);
        int n, first, last, end_cyc, bad, mx, my, exp_addr;
        bit stall;
        n = 0; first = -1; last = -1; end_cyc = -1; bad = 0;
        mx = int'(v.x0); my = int'(v.y0);
        bus.cmd_x0 = v.x0; bus.cmd_x1 = v.x1;
        bus.cmd_y0 = v.y0; bus.cmd_y1 = v.y1;
        bus.cmd_color = v.color;
        bus.cmd_valid = 1'b1;
        cpu_idle();
        #1;
        check({tag, "_ready"}, int'(bus.cmd_ready), 1);
        tick();
        bus.cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 40000; cyc++) begin
            stall = (cyc >= v.stall_lo) && (cyc <= v.stall_hi);
            bus.cpu_req  = stall;
            bus.cpu_we   = stall;
            bus.cpu_addr = stall ? 15'h0010 : 15'h0000;
            bus.cpu_din  = stall ? 12'h0AB : 12'h000;
            #1;
            if (stall) begin
                if (!(bus.mem_we && bus.mem_addr == 15'h0010 && bus.mem_din == 12'h0AB)) bad++;
            end else if (bus.mem_we) begin
                exp_addr = my * SCR_W + mx;
                if (int'(bus.mem_addr) != exp_addr || bus.mem_din != v.color || !bus.busy) bad++;
                if (n == 0) first = int'(bus.mem_addr);
                last = int'(bus.mem_addr);
                n++;
                if (mx < int'(v.x1)) mx++;
                else begin mx = int'(v.x0); my++; end
            end
            if (bus.cmd_err) end_cyc = cyc;
            if (bus.done) begin
                end_cyc = cyc;
                if (bus.busy || bus.cmd_ready) bad++;
            end
            tick();
            if (end_cyc >= 0) break;
        end
        cpu_idle();
        #1;
        check({tag, "_n"}, n, v.exp_n);
        check({tag, "_end_cyc"}, end_cyc, v.exp_end_cyc);
        check({tag, "_bad"}, bad, 0);
        if (!v.exp_err) begin
            check({tag, "_first"}, first, v.exp_first);
            check({tag, "_last"}, last, v.exp_last);
        end
        check({tag, "_post"}, {bus.done, bus.busy, bus.cmd_err, bus.cmd_ready}, 4'b0001);
    endtask

    vec_t vt [9];

    initial begin
        int wr, bad;
        vec_t one_px;
        //        x0   x1   y0   y1   color    stall  err  n      first  last   end
        vt[0] = '{8'd2,   8'd4,   8'd1,   8'd2,   12'hF00, 0, -1, 1'b0, 6,     202,   404,   7};
        vt[1] = '{8'd2,   8'd4,   8'd1,   8'd2,   12'hF00, 2,  3, 1'b0, 6,     202,   404,   9};
        vt[2] = '{8'd10,  8'd5,   8'd0,   8'd0,   12'h111, 0, -1, 1'b1, 0,     -1,    -1,    1};
        vt[3] = '{8'd0,   8'd200, 8'd0,   8'd0,   12'h222, 0, -1, 1'b1, 0,     -1,    -1,    1};
        vt[4] = '{8'd0,   8'd0,   8'd0,   8'd150, 12'h333, 0, -1, 1'b1, 0,     -1,    -1,    1};
        vt[5] = '{8'd0,   8'd0,   8'd3,   8'd1,   12'h444, 0, -1, 1'b1, 0,     -1,    -1,    1};
        vt[6] = '{8'd199, 8'd199, 8'd149, 8'd149, 12'h555, 0, -1, 1'b0, 1,     29999, 29999, 2};
        vt[7] = '{8'd0,   8'd199, 8'd5,   8'd5,   12'h0F0, 0, -1, 1'b0, 200,   1000,  1199,  201};
        vt[8] = '{8'd0,   8'd199, 8'd0,   8'd149, 12'h000, 0, -1, 1'b0, 30000, 0,     29999, 30001};
        one_px = '{8'd0, 8'd0, 8'd0, 8'd0, 12'h123, 0, -1, 1'b0, 1, 0, 0, 2};

        rstn = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = 8'd0; bus.cmd_x1 = 8'd0;
        bus.cmd_y0 = 8'd0; bus.cmd_y1 = 8'd0;
        bus.cmd_color = 12'd0;
        cpu_idle();
        tick();
        tick();
        check("rst_outputs", {bus.cmd_ready, bus.busy, bus.done, bus.cmd_err, bus.mem_we}, 5'b00000);
        rstn = 1'b1;
        #1;
        check("rst_release_ready", int'(bus.cmd_ready), 1);
        tick();

        for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("v%0d", i));

        // Abort a fill after three pixels by asserting reset
        bus.cmd_x0 = 8'd0; bus.cmd_x1 = 8'd9;
        bus.cmd_y0 = 8'd0; bus.cmd_y1 = 8'd0;
        bus.cmd_color = 12'h5A5;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        wr = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.mem_we) wr++;
            tick();
        end
        check("abort_pre_writes", wr, 3);
        rstn = 1'b0;
        #1;
        check("abort_same_cycle_we", int'(bus.mem_we), 0);
        tick();
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.busy || bus.cmd_ready || bus.mem_we || bus.done) bad++;
            tick();
        end
        check("abort_held", bad, 0);
        rstn = 1'b1;
        run_vec(one_px, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
